// File: rtl/vga_embarcacoes_ctrl.sv
// vga_embarcacoes_ctrl
// Frame-synchronous ship controller. Game logic writes position and
// visibility updates through a req/ack handshake into shadow registers.
// These are copied into the renderer-facing active registers only at the
// start of vertical blanking, so a ship never tears mid-frame. The block
// also merges the five renderer colours with a fixed priority, where the
// lowest ship index wins, into one registered RGB.
// Optional feature: define VGA_CTRL_BLINK_EN to let one ship blink with a
// half-period of BLINK_FRAMES frames.
module vga_embarcacoes_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         areaAtiva,
    input  logic [9:0]   linha,
    input  logic [9:0]   coluna,
    input  logic         upd_req,
    input  logic [2:0]   upd_id,
    input  logic [63:0]  upd_pos,
    input  logic         upd_vis,
    output logic         upd_ack,
    input  logic [2:0]   blink_id,
    input  logic [14:0]  ship_rgb,
    output logic [319:0] pos_all,
    output logic [4:0]   vis,
    output logic [4:0]   pending,
    output logic         frame_start,
    output logic         rgb_r,
    output logic         rgb_g,
    output logic         rgb_b
);

    localparam logic [9:0] V_COMMIT = 10'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t       state_q;
    logic         upd_ack_q;
    logic [63:0]  shadow_q [5];
    logic [4:0]   shadow_vis_q;
    logic [4:0]   pending_q;
    logic [319:0] pos_all_q;
    logic [4:0]   vis_q;
    logic         frame_start_q;
    logic [2:0]   rgb_q;
    logic [2:0]   pixel_d;
    logic [4:0]   capture_d;
    logic [4:0]   blank;
    logic         commit;
    logic         unused_cfg;

    // The commit point is the first pixel of the first blanking line
    assign commit = (linha == V_COMMIT) && (coluna == 10'd0);

    // Select which shadow slot a request in IDLE writes; ids 5..7 write nothing
    always_comb begin
        capture_d = 5'b00000;
        if (state_q == IDLE && upd_req) begin
            for (int i = 0; i < 5; i++) begin
                if (upd_id == 3'(i)) capture_d[i] = 1'b1;
            end
        end
    end

    // Handshake FSM: capture in IDLE, acknowledge for one cycle, then wait for the request to drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            upd_ack_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    upd_ack_q <= 1'b0;
                    if (upd_req) begin
                        state_q   <= ACK;
                        upd_ack_q <= 1'b1;
                    end
                end
                ACK: begin
                    state_q   <= HOLD;
                    upd_ack_q <= 1'b0;
                end
                HOLD: begin
                    upd_ack_q <= 1'b0;
                    if (!upd_req) state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    upd_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Shadow storage. A capture that lands on the commit cycle re-arms pending, so it goes out next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) shadow_q[i] <= 64'd0;
            shadow_vis_q <= 5'b00000;
            pending_q    <= 5'b00000;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (capture_d[i]) begin
                    shadow_q[i]     <= upd_pos;
                    shadow_vis_q[i] <= upd_vis;
                end
            end
            pending_q <= (commit ? 5'b00000 : pending_q) | capture_d;
        end
    end

    // Copy pending shadows into the active set at the commit point; this reads shadow values from before any same-cycle capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_all_q     <= '0;
            vis_q         <= 5'b00000;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= commit;
            if (commit) begin
                for (int i = 0; i < 5; i++) begin
                    if (pending_q[i]) begin
                        pos_all_q[64*i +: 64] <= shadow_q[i];
                        vis_q[i]              <= shadow_vis_q[i];
                    end
                end
            end
        end
    end

`ifdef VGA_CTRL_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] frame_cnt_q;
    logic       blink_phase_q;

    // Count frames and flip the blink phase every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else if (frame_start_q) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_q   <= 8'd0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // During the off phase hide the selected ship; ids 5..7 match no ship
    always_comb begin
        blank = 5'b00000;
        if (blink_phase_q) begin
            for (int i = 0; i < 5; i++) begin
                if (blink_id == 3'(i)) blank[i] = 1'b1;
            end
        end
    end

    assign unused_cfg = H_ACTIVE[0];
`else
    assign blank      = 5'b00000;
    assign unused_cfg = ^{blink_id, H_ACTIVE[0], BLINK_FRAMES[0]};
`endif

    // Priority merge: scan from the highest index down so that the lowest eligible ship wins
    always_comb begin
        pixel_d = 3'b000;
        for (int i = 4; i >= 0; i--) begin
            if (vis_q[i] && (|ship_rgb[3*i +: 3]) && areaAtiva && !blank[i]) begin
                pixel_d = ship_rgb[3*i +: 3];
            end
        end
    end

    // Register the merged colour for the sync stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb_q <= 3'b000;
        else        rgb_q <= pixel_d;
    end

    assign upd_ack     = upd_ack_q;
    assign pos_all     = pos_all_q;
    assign vis         = vis_q;
    assign pending     = pending_q;
    assign frame_start = frame_start_q;
    assign rgb_r       = rgb_q[2];
    assign rgb_g       = rgb_q[1];
    assign rgb_b       = rgb_q[0];

endmodule

// File: tb/tb_vga_embarcacoes_ctrl.sv
// tb_vga_embarcacoes_ctrl
// Directed bench for vga_embarcacoes_ctrl. Covers reset, the update
// handshake, the frame commit and the colour merge. The blink scenario is
// built only when VGA_CTRL_BLINK_EN is defined.
module tb_vga_embarcacoes_ctrl;

    localparam int BF = 2;

    localparam logic [63:0] P  = 64'h0000_0004_5454_3830;
    localparam logic [63:0] Q1 = 64'h0000_0001_1111_2222;
    localparam logic [63:0] Q2 = 64'h0000_0003_3333_4444;
    localparam logic [63:0] A  = 64'h0000_000A_AAAA_5555;
    localparam logic [63:0] B  = 64'h0000_000B_BBBB_6666;
    localparam logic [63:0] C  = 64'h0000_000C_CCCC_7777;
    localparam logic [63:0] X  = 64'hDEAD_BEEF_0000_0001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         areaAtiva = 1'b0;
    logic [9:0]   linha = 10'd0;
    logic [9:0]   coluna = 10'd0;
    logic         upd_req = 1'b0;
    logic [2:0]   upd_id = 3'd0;
    logic [63:0]  upd_pos = 64'd0;
    logic         upd_vis = 1'b0;
    logic         upd_ack;
    logic [2:0]   blink_id = 3'd7;
    logic [14:0]  ship_rgb = 15'd0;
    logic [319:0] pos_all;
    logic [4:0]   vis;
    logic [4:0]   pending;
    logic         frame_start;
    logic         rgb_r, rgb_g, rgb_b;

    int checks = 0;
    int failures = 0;

    vga_embarcacoes_ctrl #(
        .H_ACTIVE(640), .V_ACTIVE(480), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .areaAtiva(areaAtiva), .linha(linha),
        .coluna(coluna), .upd_req(upd_req), .upd_id(upd_id), .upd_pos(upd_pos),
        .upd_vis(upd_vis), .upd_ack(upd_ack), .blink_id(blink_id),
        .ship_rgb(ship_rgb), .pos_all(pos_all), .vis(vis), .pending(pending),
        .frame_start(frame_start), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
    );

    always #5 clk = ~clk;

    // Safety net so that the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        linha  = 10'd100;
        coluna = 10'd5;
    endtask

    task automatic goto_commit();
        linha  = 10'd480;
        coluna = 10'd0;
        tick();
    endtask

    task automatic do_update(input logic [2:0] id, input logic [63:0] pos, input logic v);
        upd_id  = id;
        upd_pos = pos;
        upd_vis = v;
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({upd_ack, frame_start, vis, pending, rgb_r, rgb_g, rgb_b} !== 15'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b want=0", {upd_ack, frame_start, vis, pending, rgb_r, rgb_g, rgb_b});
        end
        checks++;
        if (pos_all !== 320'd0) begin
            failures++;
            $display("[TB] FAIL reset_pos_all got=%h want=0", pos_all);
        end
        rst_n = 1'b1;
        park();
        tick();
    endtask

    task automatic test_reset_mid_handshake();
        upd_id = 3'd2; upd_pos = A; upd_vis = 1'b1; upd_req = 1'b1;
        tick();
        checks++;
        if (pending !== 5'b00100 || upd_ack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_capture pending=%b ack=%b want=00100/1", pending, upd_ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pending !== 5'b00000 || upd_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_async pending=%b ack=%b want=00000/0", pending, upd_ack);
        end
        upd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_frame();
        linha = 10'd479; coluna = 10'd0;
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_no_pulse_479 got=%b want=0", frame_start);
        end
        goto_commit();
        checks++;
        if (frame_start !== 1'b1 || pos_all !== 320'd0 || vis !== 5'd0) begin
            failures++;
            $display("[TB] FAIL idle_commit fs=%b vis=%b want fs=1 vis=0 pos=0", frame_start, vis);
        end
        coluna = 10'd1;
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_pulse_width got=%b want=0", frame_start);
        end
        park();
    endtask

    task automatic test_update();
        upd_id = 3'd3; upd_pos = P; upd_vis = 1'b1; upd_req = 1'b1;
        tick();
        checks++;
        if (upd_ack !== 1'b1 || pending !== 5'b01000 || pos_all !== 320'd0) begin
            failures++;
            $display("[TB] FAIL update_capture ack=%b pending=%b want 1/01000, pos unchanged", upd_ack, pending);
        end
        upd_req = 1'b0;
        tick();
        checks++;
        if (upd_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL update_ack_width got=%b want=0", upd_ack);
        end
        tick();
        linha = 10'd479;
        tick();
        checks++;
        if (pos_all !== 320'd0 || vis !== 5'd0) begin
            failures++;
            $display("[TB] FAIL update_before_commit vis=%b want=0, pos unchanged", vis);
        end
        goto_commit();
        checks++;
        if (pos_all !== ({256'd0, P} << 192) || vis !== 5'b01000 || pending !== 5'd0 || frame_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL update_commit ship3=%h vis=%b pending=%b want %h/01000/00000", pos_all[255:192], vis, pending, P);
        end
        park();
    endtask

    task automatic test_same_cycle_commit();
        do_update(3'd3, Q1, 1'b1);
        linha = 10'd480; coluna = 10'd0;
        upd_id = 3'd3; upd_pos = Q2; upd_vis = 1'b1; upd_req = 1'b1;
        tick();
        checks++;
        if (pos_all[255:192] !== Q1 || pending !== 5'b01000 || upd_ack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL same_cycle_commit ship3=%h pending=%b ack=%b want %h/01000/1", pos_all[255:192], pending, upd_ack, Q1);
        end
        coluna = 10'd1;
        upd_req = 1'b0;
        tick();
        tick();
        goto_commit();
        checks++;
        if (pos_all[255:192] !== Q2 || pending !== 5'd0) begin
            failures++;
            $display("[TB] FAIL same_cycle_next_frame ship3=%h pending=%b want %h/00000", pos_all[255:192], pending, Q2);
        end
        park();
    endtask

    task automatic test_invalid_id();
        int acks;
        acks = 0;
        upd_id = 3'd6; upd_pos = X; upd_vis = 1'b1; upd_req = 1'b1;
        tick();
        checks++;
        if (upd_ack !== 1'b1 || pending !== 5'd0) begin
            failures++;
            $display("[TB] FAIL invalid_id_ack ack=%b pending=%b want 1/00000", upd_ack, pending);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (upd_ack === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("[TB] FAIL held_req_second_ack got=%0d want=0", acks);
        end
        upd_req = 1'b0;
        tick();
        tick();
        goto_commit();
        checks++;
        if (pos_all !== ({256'd0, Q2} << 192) || vis !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL invalid_id_no_write vis=%b ship3=%h want 01000/%h", vis, pos_all[255:192], Q2);
        end
        park();
    endtask

    task automatic test_back_to_back();
        upd_id = 3'd0; upd_pos = A; upd_vis = 1'b1; upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        tick();
        tick();
        upd_pos = B; upd_vis = 1'b0; upd_req = 1'b1;
        tick();
        checks++;
        if (upd_ack !== 1'b1 || pending !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL back_to_back_capture ack=%b pending=%b want 1/00001", upd_ack, pending);
        end
        upd_req = 1'b0;
        tick();
        tick();
        do_update(3'd1, C, 1'b1);
        goto_commit();
        checks++;
        if (pos_all !== {64'd0, Q2, 64'd0, C, B} || vis !== 5'b01010 || pending !== 5'd0) begin
            failures++;
            $display("[TB] FAIL last_write_wins ship0=%h ship1=%h vis=%b want %h/%h/01010", pos_all[63:0], pos_all[127:64], vis, B, C);
        end
        park();
    endtask

    task automatic test_pixel_merge();
        linha = 10'd10; coluna = 10'd20;
        blink_id = 3'd7;
        ship_rgb = 15'b000_011_000_101_111;
        areaAtiva = 1'b1;
        tick();
        checks++;
        if ({rgb_r, rgb_g, rgb_b} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL merge_priority got=%b want=101", {rgb_r, rgb_g, rgb_b});
        end
        areaAtiva = 1'b0;
        #1;
        checks++;
        if ({rgb_r, rgb_g, rgb_b} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL merge_latency got=%b want=101", {rgb_r, rgb_g, rgb_b});
        end
        tick();
        checks++;
        if ({rgb_r, rgb_g, rgb_b} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL merge_blanking got=%b want=000", {rgb_r, rgb_g, rgb_b});
        end
        areaAtiva = 1'b1;
        ship_rgb = 15'b000_011_000_000_111;
        tick();
        checks++;
        if ({rgb_r, rgb_g, rgb_b} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL merge_fallthrough got=%b want=011", {rgb_r, rgb_g, rgb_b});
        end
        ship_rgb = 15'b000_011_000_101_111;
    endtask

`ifdef VGA_CTRL_BLINK_EN
    task automatic test_blink();
        logic [2:0] want;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        park();
        areaAtiva = 1'b1;
        blink_id = 3'd1;
        ship_rgb = 15'b000_011_000_101_000;
        do_update(3'd1, C, 1'b1);
        do_update(3'd3, Q2, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            goto_commit();
            park();
            tick();
            tick();
            want = (k == 2 || k == 3) ? 3'b011 : 3'b101;
            checks++;
            if ({rgb_r, rgb_g, rgb_b} !== want) begin
                failures++;
                $display("[TB] FAIL blink_frame%0d got=%b want=%b", k, {rgb_r, rgb_g, rgb_b}, want);
            end
        end
    endtask
`else
    task automatic test_blink_ignored();
        blink_id = 3'd1;
        for (int k = 1; k <= 3; k++) begin
            goto_commit();
            linha = 10'd10; coluna = 10'd20;
            tick();
            tick();
            checks++;
            if ({rgb_r, rgb_g, rgb_b} !== 3'b101) begin
                failures++;
                $display("[TB] FAIL blink_ignored_frame%0d got=%b want=101", k, {rgb_r, rgb_g, rgb_b});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_handshake();
        test_idle_frame();
        test_update();
        test_same_cycle_commit();
        test_invalid_id();
        test_back_to_back();
        test_pixel_merge();
`ifdef VGA_CTRL_BLINK_EN
        test_blink();
`else
        test_blink_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
